// File: rtl/spram_pkg.sv
// Shared types and constants for the single-port RAM arbiter.
package spram_pkg;

    localparam int unsigned RamAddrW = 15;
    localparam logic [RamAddrW-1:0] RamLastAddr = '1;

    typedef enum logic {
        StClear = 1'b0,
        StRun   = 1'b1
    } state_e;

    // One-hot port select, matches the rr_arb2 grant vector bit order.
    typedef enum logic [1:0] {
        SelNone = 2'b00,
        SelA    = 2'b01,
        SelB    = 2'b10
    } port_sel_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with one-hot combinational grant.
module rr_arb2
    import spram_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Set when port B (bit 1) holds the most recent grant.
    logic last_b_q, last_b_d;

    always_comb begin
        gnt = SelNone;
        case (req)
            2'b01:   gnt = SelA;
            2'b10:   gnt = SelB;
            2'b11:   gnt = last_b_q ? SelA : SelB;
            default: gnt = SelNone;
        endcase
    end

    always_comb begin
        last_b_d = last_b_q;
        if (gnt != SelNone) begin
            last_b_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of a 32 KiB single-port RAM.
// Define SPRAM_ARB_CLEAR_EN to sweep CLEAR_VALUE through the RAM after reset.
module spram_arbiter
    import spram_pkg::*;
#(
    parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                a_req,
    input  logic                a_we,
    input  logic [RamAddrW-1:0] a_addr,
    input  logic [7:0]          a_din,
    output logic                a_gnt,
    output logic                a_rvalid,
    output logic [7:0]          a_rdata,

    input  logic                b_req,
    input  logic                b_we,
    input  logic [RamAddrW-1:0] b_addr,
    input  logic [7:0]          b_din,
    output logic                b_gnt,
    output logic                b_rvalid,
    output logic [7:0]          b_rdata,

    input  logic [7:0]          wp,

    output logic                ram_sel,
    output logic                ram_we,
    output logic [RamAddrW-1:0] ram_addr,
    output logic [7:0]          ram_din,
    output logic [7:0]          ram_wp,
    input  logic [7:0]          ram_dout,

    output logic                busy
);

    logic      run;
    logic [1:0] arb_req;
    logic [1:0] arb_gnt;
    port_sel_e sel;
    logic      a_rd_q, b_rd_q;

`ifdef SPRAM_ARB_CLEAR_EN
    state_e              state_q, state_d;
    logic [RamAddrW-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // Counter holds at the last address instead of wrapping.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == StClear) begin
            if (clr_addr_q == RamLastAddr) begin
                state_d = StRun;
            end else begin
                clr_addr_d = clr_addr_q + 1'b1;
            end
        end
    end

    assign run  = (state_q == StRun);
    assign busy = (state_q == StClear);
`else
    logic unused_clear_value;

    assign unused_clear_value = ^CLEAR_VALUE;
    assign run  = 1'b1;
    assign busy = 1'b0;
`endif

    // Requests stay pending while clearing or in reset; nothing is granted.
    assign arb_req = (run && !reset) ? {b_req, a_req} : 2'b00;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (arb_req),
        .gnt   (arb_gnt)
    );

    assign sel   = port_sel_e'(arb_gnt);
    assign a_gnt = arb_gnt[0];
    assign b_gnt = arb_gnt[1];

    always_comb begin
        ram_sel  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        ram_wp   = wp;
        unique case (sel)
            SelA: begin
                ram_sel  = 1'b1;
                ram_we   = a_we;
                ram_addr = a_addr;
                ram_din  = a_din;
            end
            SelB: begin
                ram_sel  = 1'b1;
                ram_we   = b_we;
                ram_addr = b_addr;
                ram_din  = b_din;
            end
            default: ;
        endcase
`ifdef SPRAM_ARB_CLEAR_EN
        if (state_q == StClear) begin
            ram_sel  = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clr_addr_q;
            ram_din  = CLEAR_VALUE;
            ram_wp   = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_rd_q <= 1'b0;
            b_rd_q <= 1'b0;
        end else begin
            a_rd_q <= arb_gnt[0] & ~a_we;
            b_rd_q <= arb_gnt[1] & ~b_we;
        end
    end

    // Gating with reset drops a read response that is in flight when reset hits.
    assign a_rvalid = a_rd_q & ~reset;
    assign b_rvalid = b_rd_q & ~reset;
    assign a_rdata  = ram_dout;
    assign b_rdata  = ram_dout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter with a behavioural write-protected RAM.
module tb_spram_arbiter;

`ifdef SPRAM_ARB_CLEAR_EN
    localparam bit ClearEn = 1'b1;
`else
    localparam bit ClearEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [14:0] a_addr, b_addr;
    logic [7:0]  a_din, b_din;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [7:0]  a_rdata, b_rdata;
    logic [7:0]  wp;
    logic        ram_sel, ram_we;
    logic [14:0] ram_addr;
    logic [7:0]  ram_din, ram_wp;
    logic [7:0]  ram_dout = 8'h00;
    logic        busy;

    logic [7:0]  mem [0:32767];
    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    logic [7:0]  pop_a, pop_b;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    spram_arbiter #(.CLEAR_VALUE(8'h00)) dut (
        .clk      (clk),
        .reset    (reset),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_din    (a_din),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_din    (b_din),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata),
        .wp       (wp),
        .ram_sel  (ram_sel),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_wp   (ram_wp),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    // RAM model: one 4 KiB block per write-protect bit, registered read.
    always @(posedge clk) begin
        if (ram_sel) begin
            if (ram_we) begin
                if (!ram_wp[ram_addr[14:12]]) mem[ram_addr] <= ram_din;
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gnt_chk(input string name, input logic ga, input logic gb);
        check({name, "_gnt"}, {30'd0, b_gnt, a_gnt}, {30'd0, gb, ga});
    endtask

    task automatic ram_chk(input string name, input logic we, input logic [14:0] addr,
                           input logic [7:0] din);
        check({name, "_ram"}, {7'd0, ram_sel, ram_we, ram_addr, ram_din},
              {7'd0, 1'b1, we, addr, din});
    endtask

    // Monitor: every rvalid pops the next expected byte of that port.
    always @(negedge clk) begin
        if (a_rvalid === 1'b1) begin
            if (exp_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_rdata: got rvalid with %h, expected no response", a_rdata);
            end else begin
                pop_a = exp_a.pop_front();
                check("a_rdata", {24'd0, a_rdata}, {24'd0, pop_a});
            end
        end
        if (b_rvalid === 1'b1) begin
            if (exp_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_rdata: got rvalid with %h, expected no response", b_rdata);
            end else begin
                pop_b = exp_b.pop_front();
                check("b_rdata", {24'd0, b_rdata}, {24'd0, pop_b});
            end
        end
    end

    logic       tbl_ga  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       tbl_arv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       tbl_brv [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       first_a;
    int         bad;

    initial begin
        reset = 1'b1;
        wp    = 8'hA5;
        a_req = ClearEn; a_we = 1'b0; a_addr = 15'h0010; a_din = 8'h00;
        b_req = 1'b0;    b_we = 1'b0; b_addr = 15'h0000; b_din = 8'h00;
        repeat (2) tick();

        // Reset state
        @(negedge clk);
        gnt_chk("reset", 1'b0, 1'b0);
        check("reset_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("reset_busy", {31'd0, busy}, {31'd0, ClearEn});
        check("reset_sel", {30'd0, ram_sel, ram_we}, {30'd0, ClearEn, ClearEn});
        check("reset_wp", {24'd0, ram_wp}, ClearEn ? 32'h00 : 32'hA5);
        tick();
        wp    = 8'h00;
        reset = 1'b0;

`ifdef SPRAM_ARB_CLEAR_EN
        // Partial sweep, then reset at address 0400 must restart from 0000.
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || ram_addr !== i[14:0] || a_gnt !== 1'b0) bad++;
            tick();
        end
        check("clear_partial", bad, 0);
        @(negedge clk);
        check("clear_at_400", {17'd0, ram_addr}, 32'h0400);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || ram_sel !== 1'b1 || ram_we !== 1'b1 || ram_addr !== i[14:0] ||
                ram_din !== 8'h00 || ram_wp !== 8'h00 || a_gnt !== 1'b0 || b_gnt !== 1'b0) bad++;
            tick();
        end
        check("clear_sweep", bad, 0);
        exp_a.push_back(8'h00);
        @(negedge clk);
        check("clear_done_busy", {31'd0, busy}, 32'd0);
        gnt_chk("clear_done", 1'b1, 1'b0);
        ram_chk("clear_done", 1'b0, 15'h0010, 8'h00);
        tick();
        a_req = 1'b0;
        tick();
`endif

        // Preload by contest: A writes 0010=11, B writes 0020=22
        first_a = !ClearEn;
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h0010; a_din = 8'h11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0020; b_din = 8'h22;
        @(negedge clk);
        gnt_chk("pre0", first_a, !first_a);
        tick();
        if (first_a) a_req = 1'b0; else b_req = 1'b0;
        @(negedge clk);
        gnt_chk("pre1", !first_a, first_a);
        tick();
        a_req = 1'b0;
        b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0100; b_din = 8'h77;
        @(negedge clk);
        gnt_chk("b_solo_wr", 1'b0, 1'b1);
        ram_chk("b_solo_wr", 1'b1, 15'h0100, 8'h77);
        tick();

        // Both read continuously: A,B,A,B with data one cycle later
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010; a_din = 8'h00;
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0020; b_din = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (tbl_ga[k]) exp_a.push_back(8'h11); else exp_b.push_back(8'h22);
            @(negedge clk);
            gnt_chk("rr", tbl_ga[k], !tbl_ga[k]);
            ram_chk("rr", 1'b0, tbl_ga[k] ? 15'h0010 : 15'h0020, 8'h00);
            check("rr_rvalid", {30'd0, a_rvalid, b_rvalid}, {30'd0, tbl_arv[k], tbl_brv[k]});
            tick();
        end
        a_req = 1'b0; b_req = 1'b0;
        @(negedge clk);
        check("rr_last_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd1);
        check("idle_sel", {30'd0, ram_sel, ram_we}, 32'd0);
        tick();

        // A writes 5A to 1234, then reads it back
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h1234; a_din = 8'h5A;
        @(negedge clk);
        gnt_chk("a_wr", 1'b1, 1'b0);
        ram_chk("a_wr", 1'b1, 15'h1234, 8'h5A);
        tick();
        a_we = 1'b0; a_din = 8'h00;
        exp_a.push_back(8'h5A);
        @(negedge clk);
        gnt_chk("a_rd", 1'b1, 1'b0);
        check("a_wr_no_rvalid", {31'd0, a_rvalid}, 32'd0);
        tick();
        a_req = 1'b0;
        @(negedge clk);
        check("a_rd_rvalid", {31'd0, a_rvalid}, 32'd1);
        tick();

        // Write protect on block 0: B write to 0100 is dropped by the RAM
        wp = 8'h01;
        b_req = 1'b1; b_we = 1'b1; b_addr = 15'h0100; b_din = 8'h99;
        @(negedge clk);
        gnt_chk("wp_wr", 1'b0, 1'b1);
        ram_chk("wp_wr", 1'b1, 15'h0100, 8'h99);
        check("wp_pass", {24'd0, ram_wp}, 32'h01);
        tick();
        b_we = 1'b0; b_din = 8'h00;
        exp_b.push_back(8'h77);
        @(negedge clk);
        gnt_chk("wp_rd", 1'b0, 1'b1);
        tick();
        b_req = 1'b0;
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'h1100; a_din = 8'h3C;
        @(negedge clk);
        gnt_chk("nowp_wr", 1'b1, 1'b0);
        tick();
        a_we = 1'b0; a_din = 8'h00;
        exp_a.push_back(8'h3C);
        @(negedge clk);
        gnt_chk("nowp_rd", 1'b1, 1'b0);
        tick();
        a_req = 1'b0;
        wp = 8'h00;
        tick();

        // Contest after an A grant: B wins first
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h1234;
        b_req = 1'b1; b_we = 1'b0; b_addr = 15'h0100;
        exp_b.push_back(8'h77);
        @(negedge clk);
        gnt_chk("rr_b_first", 1'b0, 1'b1);
        tick();
        b_req = 1'b0;
        exp_a.push_back(8'h5A);
        @(negedge clk);
        gnt_chk("rr_a_second", 1'b1, 1'b0);
        tick();
        a_req = 1'b0;
        tick();

        // Reset the cycle after a granted read: no rvalid
        a_req = 1'b1; a_we = 1'b0; a_addr = 15'h0010;
        @(negedge clk);
        gnt_chk("rst_rd", 1'b1, 1'b0);
        tick();
        a_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_rd_rvalid0", {31'd0, a_rvalid}, 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_rd_rvalid1", {31'd0, a_rvalid}, 32'd0);
        tick();
        tick();

        check("exp_a_drained", exp_a.size(), 0);
        check("exp_b_drained", exp_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
